dsp_timed_counter: RTL and testbench
====================================

DSP_TIMED_COUNTER -- requirements
Module: dsp_timed_counter

Interface
REQ-001 SHALL have parameter MODE, default "NORMAL"; legal values "NORMAL" (free-running windows, one-cycle valid strobe) and "ACKNOWLEDGE" (one window, result held until acknowledged).
REQ-002 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high; in ACKNOWLEDGE mode it is also the result acknowledge.
REQ-004 SHALL have port count_in  input  1  event qualifier; each clk cycle it is high adds 1 to the count.
REQ-005 SHALL have port interval_in  input  24  window length N in clk cycles.
REQ-006 SHALL have port interval_load  input  1  one-cycle strobe that captures interval_in.
REQ-007 SHALL have port count_out  output  24  count of count_in-high cycles in the last completed window.
REQ-008 SHALL have port count_out_valid  output  1  count_out update indicator.

Function
REQ-009 SHALL hold N in an interval register written only by interval_load; its power-up value is 0.
REQ-010 SHALL treat N=0 as disabled: no counting, count_out_valid stays 0.
REQ-011 SHALL start a window on the first cycle after interval_load (or after rst deasserts) and end it N cycles later; count_in is sampled on each of these N edges.
REQ-012 SHALL, on the edge ending a window, load count_out with the accumulated total including that final cycle's sample, and assert count_out_valid on the following cycle.
REQ-013 SHALL, in NORMAL mode, hold count_out_valid high for exactly one cycle per window, then start the next window immediately with no dead cycle and the accumulator restarted from 0.
REQ-014 SHALL, in ACKNOWLEDGE mode, hold count_out_valid high and count_out stable after the first window, ignoring count_in, until rst is asserted.
REQ-015 SHALL, on interval_load mid-window, discard the partial count, leave count_out and count_out_valid unchanged, and start a new window of the new N.
REQ-016 SHALL handle N=1 as a single-cycle window: in NORMAL mode valid asserts every cycle and count_out equals the count_in sampled on the previous edge.
REQ-017 SHALL use 24-bit unsigned arithmetic; count_out never exceeds N, so no saturation logic is needed.

Reset
REQ-018 SHALL, while rst is high, asynchronously clear count_out, count_out_valid, the accumulator and the window timer.
REQ-019 SHALL preserve the interval register across rst.
REQ-020 SHALL begin a fresh window on the first edge after rst deasserts, if N is not 0.

Structure
REQ-021 SHALL take the MODE string constants and the 24-bit width localparam from a shared package, dsp_timed_counter_pkg.
REQ-022 SHALL build the window timer and the event accumulator from one reusable sub-module, dsp_counter24, which provides a 24-bit load/clear/increment-or-decrement counter mappable to a DSP slice.

Verification
REQ-023 SHALL cover: 10 ns clk; load N=50, hold count_in high for 10 consecutive cycles inside one window -> NORMAL gives count_out=10 with a one-cycle valid, and the next windows give count_out=0 with a valid every 50 cycles.
REQ-024 SHALL cover: the same stimulus in ACKNOWLEDGE mode -> valid rises and stays high with count_out=10 indefinitely; a one-cycle rst pulse clears both outputs, and valid returns exactly 50 cycles after rst deasserts.
REQ-025 SHALL cover: N=50, count_in high for 6 cycles straddling a window boundary (3 before, 3 after) -> two consecutive results of 3 and 3.
REQ-026 SHALL cover: interval_load with N=20 at cycle 30 of a 50-cycle window -> no result for the old window, and the next valid arrives 20 cycles after the load.
REQ-027 SHALL cover: never loaded (N=0) with count_in toggling -> count_out_valid never asserts; N=1 with count_in constantly 1 -> valid every cycle and count_out=1.

Source files
------------

// File: rtl/dsp_timed_counter_pkg.sv
// Shared constants for the windowed event counter: datapath width and MODE strings.
package dsp_timed_counter_pkg;

    localparam int    CNT_W       = 24;
    localparam string MODE_NORMAL = "NORMAL";
    localparam string MODE_ACK    = "ACKNOWLEDGE";

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dsp_counter24.sv
// 24-bit counter with clear > load > step priority; shaped so it maps onto a DSP accumulator.
module dsp_counter24
    import dsp_timed_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             dn,
    output logic [CNT_W-1:0] q
);

    cnt_t q_q;
    cnt_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = q_q + (dn ? {CNT_W{1'b1}} : cnt_t'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dsp_timed_counter.sv
// Counts count_in-high cycles over windows of N clk cycles and publishes each window's total.
module dsp_timed_counter
    import dsp_timed_counter_pkg::*;
#(
    parameter string MODE = MODE_NORMAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_in,
    input  logic [CNT_W-1:0] interval_in,
    input  logic             interval_load,
    output logic [CNT_W-1:0] count_out,
    output logic             count_out_valid
);

    localparam bit IS_ACK = (MODE == MODE_ACK);

    // Interval survives rst; only its power-up value is defined.
    cnt_t interval_q = '0;
    cnt_t interval_d;
    cnt_t count_out_q;
    cnt_t count_out_d;
    logic valid_q;
    logic valid_d;

    cnt_t timer_q;
    cnt_t acc_q;
    cnt_t rem;
    logic active;
    logic win_end;

    // timer_q == 0 marks the first edge of a window, so a cleared timer restarts cleanly.
    always_comb begin
        active      = (interval_q != '0) && !(IS_ACK && valid_q);
        rem         = (timer_q == '0) ? interval_q : timer_q;
        win_end     = active && !interval_load && (rem == cnt_t'(1));
        interval_d  = interval_load ? interval_in : interval_q;
        count_out_d = win_end ? (acc_q + cnt_t'(count_in)) : count_out_q;
        valid_d     = IS_ACK ? (valid_q || win_end) : win_end;
    end

    dsp_counter24 u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (interval_load || win_end),
        .load     (active && (timer_q == '0)),
        .load_val (interval_q - cnt_t'(1)),
        .en       (active),
        .dn       (1'b1),
        .q        (timer_q)
    );

    dsp_counter24 u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (interval_load || win_end || !active),
        .load     (1'b0),
        .load_val ('0),
        .en       (count_in),
        .dn       (1'b0),
        .q        (acc_q)
    );

    always_ff @(posedge clk) begin
        interval_q <= interval_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            count_out_q <= count_out_d;
            valid_q     <= valid_d;
        end
    end

    assign count_out       = count_out_q;
    assign count_out_valid = valid_q;

endmodule

// File: tb/tb_dsp_timed_counter.sv
// Directed bench: one NORMAL and one ACKNOWLEDGE instance share stimulus, each with its own rst.
module tb_dsp_timed_counter;

    logic        clk = 1'b0;
    logic        rst_nm;
    logic        rst_ak;
    logic        count_in;
    logic [23:0] interval_in;
    logic        interval_load;
    logic [23:0] cnt_nm, cnt_ak;
    logic        vld_nm, vld_ak;

    int errors = 0;
    int checks = 0;
    logic seen;

    always #5 clk = ~clk;

    dsp_timed_counter #(.MODE("NORMAL")) dut_nm (
        .clk             (clk),
        .rst             (rst_nm),
        .count_in        (count_in),
        .interval_in     (interval_in),
        .interval_load   (interval_load),
        .count_out       (cnt_nm),
        .count_out_valid (vld_nm)
    );

    dsp_timed_counter #(.MODE("ACKNOWLEDGE")) dut_ak (
        .clk             (clk),
        .rst             (rst_ak),
        .count_in        (count_in),
        .interval_in     (interval_in),
        .interval_load   (interval_load),
        .count_out       (cnt_ak),
        .count_out_valid (vld_ak)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_n(input logic [23:0] n);
        interval_in   = n;
        interval_load = 1'b1;
        tick();
        interval_load = 1'b0;
    endtask

    initial begin
        rst_nm = 1'b1; rst_ak = 1'b1;
        count_in = 1'b0; interval_in = '0; interval_load = 1'b0;
        #1;
        chk("rst_nm_valid", {23'd0, vld_nm}, 24'd0);
        chk("rst_nm_count", cnt_nm, 24'd0);
        chk("rst_ak_valid", {23'd0, vld_ak}, 24'd0);
        tick(2);
        rst_nm = 1'b0; rst_ak = 1'b0;

        // never loaded: N=0 must not count
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            count_in = ~count_in;
            tick();
            seen = seen | vld_nm | vld_ak;
        end
        count_in = 1'b0;
        chk("n0_no_valid", {23'd0, seen}, 24'd0);
        chk("n0_count", cnt_nm, 24'd0);

        // N=50, count_in high on window edges 5..14
        load_n(24'd50);
        tick(4);
        count_in = 1'b1;
        tick(10);
        count_in = 1'b0;
        tick(35);
        chk("w1_nm_valid_early", {23'd0, vld_nm}, 24'd0);
        chk("w1_ak_valid_early", {23'd0, vld_ak}, 24'd0);
        tick();
        chk("w1_nm_valid", {23'd0, vld_nm}, 24'd1);
        chk("w1_nm_count", cnt_nm, 24'd10);
        chk("w1_ak_valid", {23'd0, vld_ak}, 24'd1);
        chk("w1_ak_count", cnt_ak, 24'd10);
        tick();
        chk("w1_nm_strobe_drop", {23'd0, vld_nm}, 24'd0);
        chk("w1_nm_count_hold", cnt_nm, 24'd10);
        chk("w1_ak_hold", {23'd0, vld_ak}, 24'd1);
        tick(48);
        chk("w2_nm_valid_early", {23'd0, vld_nm}, 24'd0);
        tick();
        chk("w2_nm_valid", {23'd0, vld_nm}, 24'd1);
        chk("w2_nm_count", cnt_nm, 24'd0);
        chk("w2_ak_count_hold", cnt_ak, 24'd10);
        chk("w2_ak_valid_hold", {23'd0, vld_ak}, 24'd1);

        // acknowledge via a one-cycle rst pulse
        rst_ak = 1'b1;
        #1;
        chk("ack_clr_valid", {23'd0, vld_ak}, 24'd0);
        chk("ack_clr_count", cnt_ak, 24'd0);
        tick();
        rst_ak = 1'b0;
        tick(49);
        chk("ack_valid_early", {23'd0, vld_ak}, 24'd0);
        chk("w3_nm_valid", {23'd0, vld_nm}, 24'd1);
        chk("w3_nm_count", cnt_nm, 24'd0);
        tick();
        chk("ack_valid_50", {23'd0, vld_ak}, 24'd1);
        chk("ack_count_50", cnt_ak, 24'd0);

        // straddle: edges 48..50 of one window and 1..3 of the next
        load_n(24'd50);
        chk("ak_load_keeps_valid", {23'd0, vld_ak}, 24'd1);
        tick(47);
        count_in = 1'b1;
        tick(3);
        chk("strad_a_valid", {23'd0, vld_nm}, 24'd1);
        chk("strad_a_count", cnt_nm, 24'd3);
        tick(3);
        count_in = 1'b0;
        tick(47);
        chk("strad_b_valid", {23'd0, vld_nm}, 24'd1);
        chk("strad_b_count", cnt_nm, 24'd3);

        // reload N=20 at edge 30 of a window holding a partial count of 5
        count_in = 1'b1;
        tick(5);
        count_in = 1'b0;
        tick(25);
        load_n(24'd20);
        chk("reload_count_kept", cnt_nm, 24'd3);
        seen = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            seen = seen | vld_nm;
        end
        chk("reload_no_old_result", {23'd0, seen}, 24'd0);
        tick();
        chk("reload_valid_20", {23'd0, vld_nm}, 24'd1);
        chk("reload_count_20", cnt_nm, 24'd0);

        // N=1 with count_in held high
        load_n(24'd1);
        count_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("n1_valid", {23'd0, vld_nm}, 24'd1);
            chk("n1_count", cnt_nm, 24'd1);
        end
        count_in = 1'b0;
        tick();
        chk("n1_follow_valid", {23'd0, vld_nm}, 24'd1);
        chk("n1_follow_count", cnt_nm, 24'd0);

        // interval survives rst
        rst_nm = 1'b1;
        #1;
        chk("rst2_valid", {23'd0, vld_nm}, 24'd0);
        tick();
        rst_nm = 1'b0;
        count_in = 1'b1;
        tick();
        chk("rst2_resume_valid", {23'd0, vld_nm}, 24'd1);
        chk("rst2_resume_count", cnt_nm, 24'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
